// File: rtl/riscv_aes_sequencer.sv
// rtl/riscv_aes_sequencer.sv - command sequencer driving AES register file, cipher start and result write-back
module riscv_aes_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int WB_AW      = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [1:0]            cmd_idx_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic [1:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_wen_o,
  output logic [1:0]            rf_sel_o,
  output logic                  rf_start_o,
  input  logic                  aes_done_i,
  input  logic [127:0]          aes_data_i,
  input  logic [WB_AW-1:0]      aes_addr_i,
  output logic                  wb_req_o,
  input  logic                  wb_gnt_i,
  output logic [WB_AW-1:0]      wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_timeout_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // WAIT lasts TIMEOUT-1 cycles: expiry is taken when the counter is about to reach TIMEOUT-1
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  localparam logic [1:0] OP_DATA  = 2'd0;
  localparam logic [1:0] OP_KEY   = 2'd1;
  localparam logic [1:0] OP_ADDR  = 2'd2;
  localparam logic [1:0] OP_START = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        beat_q;
  logic [127:0]      result_q;
  logic [WB_AW-1:0]  base_q;

  logic              cmd_fire;
  logic              timeout_hit;
  logic              last_beat_fire;

  assign cmd_fire       = cmd_valid_i && (state_q == ST_IDLE);
  assign timeout_hit    = (cnt_q == CNT_LAST);
  assign last_beat_fire = wb_gnt_i && (beat_q == 2'd3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived outputs; write-back beat selects base+4k and MSW-first data
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    wb_req_o    = 1'b0;
    wb_addr_o   = '0;
    wb_wdata_o  = '0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i && (cmd_op_i == OP_START)) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done beats expiry when both land in the same cycle
        if (aes_done_i) begin
          state_d = ST_WB;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        wb_req_o   = 1'b1;
        wb_addr_o  = base_q + WB_AW'({beat_q, 2'b00});
        wb_wdata_o = result_q[127 - DATA_WIDTH*int'(beat_q) -: DATA_WIDTH];
        if (last_beat_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register-file write port and cipher start, launched one cycle after command acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_o   <= 1'b0;
      rf_start_o <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      rf_sel_o   <= '0;
    end else begin
      rf_wen_o   <= 1'b0;
      rf_start_o <= 1'b0;
      if (cmd_fire) begin
        case (cmd_op_i)
          OP_DATA: begin
            rf_wen_o   <= 1'b1;
            rf_waddr_o <= cmd_idx_i;
            rf_wdata_o <= cmd_wdata_i;
            rf_sel_o   <= 2'd0;
          end
          OP_KEY: begin
            rf_wen_o   <= 1'b1;
            rf_waddr_o <= cmd_idx_i;
            rf_wdata_o <= cmd_wdata_i;
            rf_sel_o   <= 2'd1;
          end
          OP_ADDR: begin
            rf_wen_o   <= 1'b1;
            rf_waddr_o <= 2'd1;
            rf_wdata_o <= cmd_wdata_i;
            rf_sel_o   <= 2'd3;
          end
          default: begin
            rf_start_o <= 1'b1;
          end
        endcase
      end
    end
  end

  // Timeout counter, result capture and write-back beat tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      beat_q   <= '0;
      result_q <= '0;
      base_q   <= '0;
    end else begin
      case (state_q)
        ST_START: begin
          cnt_q <= '0;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (aes_done_i) begin
            result_q <= aes_data_i;
            base_q   <= aes_addr_i;
            beat_q   <= '0;
          end
        end
        ST_WB: begin
          if (wb_gnt_i) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Completion pulse and sticky timeout flag; a new start clears the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_o        <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      done_o <= (state_q == ST_WB) && last_beat_fire;
      if (cmd_fire && (cmd_op_i == OP_START)) begin
        err_timeout_o <= 1'b0;
      end else if ((state_q == ST_WAIT) && !aes_done_i && timeout_hit) begin
        err_timeout_o <= 1'b1;
      end
    end
  end

endmodule
